writeback_regfile: RTL and testbench
====================================

# writeback_regfile

Final pipeline stage downstream of the memory stage: consumes the registered MEM-WB outputs (pc, instr, rd port), commits results to the 32-entry integer register file and counts retired instructions. Provides the decode stage's two read ports with same-cycle write bypass. Optionally buffers a commit trace in a small FIFO for a testbench or debug consumer.

## Interface
Parameters:
- XLEN, 32, data/address width
- NREGS, 32, number of architectural registers (x0 hardwired zero)
- TRACE_DEPTH, 8, trace FIFO entries; power of two, >= 2

Ports:
- clk_i  input  1  clock, all state updates on rising edge
- rst_i  input  1  one clock; reset is synchronous and active-high
- stallW_i  input  1  hold: no commit, no count, no trace push this cycle
- flushW_i  input  1  squash current entry (no commit)
- pcW_i  input  XLEN  pc of entry in WB
- instrW_i  input  XLEN  instruction in WB; all-zero = bubble
- rdW_port_i  input  rd_port_t  {addr[4:0], data[XLEN-1:0], valid}
- rs1_addr_i, rs2_addr_i  input  5  decode read addresses
- rs1_data_o, rs2_data_o  output  XLEN  read data (combinational)
- retire_cnt_o  output  64  retired instruction count
- commit_valid_o  output  1  registered: an instruction retired last cycle
- commit_pc_o, commit_instr_o  output  XLEN  registered retired pc/instr
- commit_rd_addr_o  output  5; commit_rd_data_o  output  XLEN; commit_we_o  output  1
- trace_valid_o  output  1; trace_ready_i  input  1; trace_pc_o, trace_instr_o  output  XLEN; trace_overflow_o  output  1

## Operation
- retire = !stallW_i & !flushW_i & (instrW_i != 0).
- we = retire & rdW_port_i.valid & (rdW_port_i.addr != 0); writes regs[addr] <= data.
- x0 always reads 0; writes to x0 ignored.
- Read ports: if rsN_addr_i == 0 -> 0; else if we & addr match -> rdW_port_i.data (bypass); else regs[rsN_addr_i].
- flushW_i and stallW_i both high: treated as flush (no commit).
- retire_cnt_o increments by 1 per retire; wraps 2^64-1 -> 0.
- Commit view registers capture pc/instr/rd addr/data/we every cycle; commit_valid_o <= retire.
- Trace FIFO (macro-enabled): push {pcW_i, instrW_i} on retire; pop on trace_valid_o & trace_ready_i; trace_valid_o = not empty; outputs show head entry.
  - Full & push & pop: both happen, count unchanged.
  - Full & push & no pop: entry dropped, trace_overflow_o set sticky until reset.
  - Empty & push & ready: no fall-through; entry visible next cycle.
  - Pointers wrap modulo TRACE_DEPTH.
- Reset: all regs 0, retire_cnt_o 0, commit_* 0, FIFO empty, trace_valid_o 0, trace_overflow_o 0. Reset mid-operation discards FIFO contents; concurrent retire ignored.

## Timing
- Register write: visible through read ports in the write cycle (bypass), from regs array the next cycle.
- retire_cnt_o and commit_* reflect a retire one cycle after the retiring cycle.
- Trace push-to-visible latency 1 cycle; pop takes effect at the edge.
- No combinational path from trace_ready_i to any output other than none (all trace outputs registered/state-derived).

## Configuration
- COMMIT_TRACE_EN defined: trace FIFO built as above.
- Not defined: no FIFO storage; trace_valid_o, trace_pc_o, trace_instr_o, trace_overflow_o tied 0; trace_ready_i ignored. Register file, counter, commit view unchanged.

## Test plan
- Reset then retire instr 0x00A00093 with rd {addr=1,data=0xA,valid=1} -> same cycle rs1_addr_i=1 reads 0xA (bypass); next cycle regs[1]=0xA, retire_cnt_o=1, commit_we_o=1.
- Retire with rd addr=0, data=0xFFFF_FFFF, valid=1 -> rs1 of x0 reads 0, commit_we_o=0, retire_cnt_o increments.
- Bubble (instr=0), stallW_i=1, flushW_i=1 cycles with valid rd to x5=0x55 -> x5 stays 0, retire_cnt_o unchanged.
- COMMIT_TRACE_EN, ready=0, 9 retires pc 0x0..0x20 -> 8 entries held, trace_overflow_o=1 after 9th; then ready=1 drains pc 0x0..0x1C in order, trace_valid_o falls after 8 pops.
- Full FIFO with simultaneous push+pop -> no overflow, newest entry retained; assert rst_i mid-drain -> trace_valid_o=0, retire_cnt_o=0, all regs read 0 next cycle.
- Preload retire_cnt via 2^64-1 forced value (backdoor) then one retire -> retire_cnt_o=0.

Source files
------------

// File: rtl/writeback_regfile.sv
// writeback_regfile: WB-stage commit into the integer register file, retire counter,
// commit view registers and an optional commit trace FIFO (build with COMMIT_TRACE_EN).
package writeback_regfile_pkg;
  localparam int unsigned RD_XLEN = 32;

  typedef struct packed {
    logic [4:0]         addr;
    logic [RD_XLEN-1:0] data;
    logic               valid;
  } rd_port_t;
endpackage

module writeback_regfile
  import writeback_regfile_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned NREGS       = 32,
  parameter int unsigned TRACE_DEPTH = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            stallW_i,
  input  logic            flushW_i,
  input  logic [XLEN-1:0] pcW_i,
  input  logic [XLEN-1:0] instrW_i,
  input  rd_port_t        rdW_port_i,
  input  logic [4:0]      rs1_addr_i,
  input  logic [4:0]      rs2_addr_i,
  output logic [XLEN-1:0] rs1_data_o,
  output logic [XLEN-1:0] rs2_data_o,
  output logic [63:0]     retire_cnt_o,
  output logic            commit_valid_o,
  output logic [XLEN-1:0] commit_pc_o,
  output logic [XLEN-1:0] commit_instr_o,
  output logic [4:0]      commit_rd_addr_o,
  output logic [XLEN-1:0] commit_rd_data_o,
  output logic            commit_we_o,
  output logic            trace_valid_o,
  input  logic            trace_ready_i,
  output logic [XLEN-1:0] trace_pc_o,
  output logic [XLEN-1:0] trace_instr_o,
  output logic            trace_overflow_o
);

  logic            retire;
  logic            we;
  logic [XLEN-1:0] regs_q [NREGS];

  // Flush wins over stall; an all-zero instruction is a bubble.
  assign retire = !stallW_i && !flushW_i && (instrW_i != '0);
  assign we     = retire && rdW_port_i.valid && (rdW_port_i.addr != 5'd0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= '0;
    end else if (we) begin
      regs_q[rdW_port_i.addr] <= rdW_port_i.data;
    end
  end

  always_comb begin
    rs1_data_o = regs_q[rs1_addr_i];
    if (rs1_addr_i == 5'd0) rs1_data_o = '0;
    else if (we && (rdW_port_i.addr == rs1_addr_i)) rs1_data_o = rdW_port_i.data;
  end

  always_comb begin
    rs2_data_o = regs_q[rs2_addr_i];
    if (rs2_addr_i == 5'd0) rs2_data_o = '0;
    else if (we && (rdW_port_i.addr == rs2_addr_i)) rs2_data_o = rdW_port_i.data;
  end

  logic [63:0] retire_cnt_q, retire_cnt_d;

  assign retire_cnt_d = retire ? retire_cnt_q + 64'd1 : retire_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) retire_cnt_q <= '0;
    else       retire_cnt_q <= retire_cnt_d;
  end

  assign retire_cnt_o = retire_cnt_q;

  // Commit view samples the WB inputs every cycle; only valid/we qualify them.
  logic            commit_valid_q;
  logic [XLEN-1:0] commit_pc_q, commit_instr_q, commit_rd_data_q;
  logic [4:0]      commit_rd_addr_q;
  logic            commit_we_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      commit_valid_q   <= 1'b0;
      commit_pc_q      <= '0;
      commit_instr_q   <= '0;
      commit_rd_addr_q <= '0;
      commit_rd_data_q <= '0;
      commit_we_q      <= 1'b0;
    end else begin
      commit_valid_q   <= retire;
      commit_pc_q      <= pcW_i;
      commit_instr_q   <= instrW_i;
      commit_rd_addr_q <= rdW_port_i.addr;
      commit_rd_data_q <= rdW_port_i.data;
      commit_we_q      <= we;
    end
  end

  assign commit_valid_o   = commit_valid_q;
  assign commit_pc_o      = commit_pc_q;
  assign commit_instr_o   = commit_instr_q;
  assign commit_rd_addr_o = commit_rd_addr_q;
  assign commit_rd_data_o = commit_rd_data_q;
  assign commit_we_o      = commit_we_q;

`ifdef COMMIT_TRACE_EN
  localparam int unsigned AW = $clog2(TRACE_DEPTH);

  logic [2*XLEN-1:0] mem_q [TRACE_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              full, pop, do_push;

  assign full    = (count_q == (AW+1)'(TRACE_DEPTH));
  assign pop     = (count_q != '0) && trace_ready_i;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = retire && (!full || pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (retire && !do_push) ovf_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && do_push) mem_q[wr_ptr_q] <= {pcW_i, instrW_i};
  end

  assign trace_valid_o    = (count_q != '0);
  assign trace_pc_o       = mem_q[rd_ptr_q][2*XLEN-1:XLEN];
  assign trace_instr_o    = mem_q[rd_ptr_q][XLEN-1:0];
  assign trace_overflow_o = ovf_q;
`else
  logic unused_trace;

  assign unused_trace     = trace_ready_i | (TRACE_DEPTH < 2);
  assign trace_valid_o    = 1'b0;
  assign trace_pc_o       = '0;
  assign trace_instr_o    = '0;
  assign trace_overflow_o = 1'b0;
`endif

endmodule

// File: tb/tb_writeback_regfile.sv
// Self-checking bench for writeback_regfile against a queue/array reference model.
`timescale 1ns/1ps
module tb_writeback_regfile;
  import writeback_regfile_pkg::*;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst, stall, flush, tready;
  logic [31:0] pc, instr;
  rd_port_t    rd_port;
  logic [4:0]  rs1, rs2;
  logic [31:0] rs1_data, rs2_data;
  logic [63:0] retire_cnt;
  logic        commit_valid, commit_we;
  logic [31:0] commit_pc, commit_instr, commit_rd_data;
  logic [4:0]  commit_rd_addr;
  logic        trace_valid, trace_ovf;
  logic [31:0] trace_pc, trace_instr;

  always #5 clk = ~clk;

  writeback_regfile #(.XLEN(32), .NREGS(32), .TRACE_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst), .stallW_i(stall), .flushW_i(flush),
    .pcW_i(pc), .instrW_i(instr), .rdW_port_i(rd_port),
    .rs1_addr_i(rs1), .rs2_addr_i(rs2), .rs1_data_o(rs1_data), .rs2_data_o(rs2_data),
    .retire_cnt_o(retire_cnt), .commit_valid_o(commit_valid), .commit_pc_o(commit_pc),
    .commit_instr_o(commit_instr), .commit_rd_addr_o(commit_rd_addr),
    .commit_rd_data_o(commit_rd_data), .commit_we_o(commit_we),
    .trace_valid_o(trace_valid), .trace_ready_i(tready), .trace_pc_o(trace_pc),
    .trace_instr_o(trace_instr), .trace_overflow_o(trace_ovf)
  );

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  logic [31:0] m_regs [32];
  logic [63:0] m_cnt;
  logic        m_cv, m_cwe, m_ovf;
  logic [31:0] m_cpc, m_cinstr, m_crd_data;
  logic [4:0]  m_crd_addr;
  logic [63:0] m_fifo [$];

  function automatic bit m_retire();
    return !stall && !flush && (instr != 0);
  endfunction

  function automatic bit m_we();
    return m_retire() && rd_port.valid && (rd_port.addr != 0);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (m_we() && a == rd_port.addr) return rd_port.data;
    return m_regs[a];
  endfunction

  task automatic drive(input logic s, input logic f, input logic [31:0] p, input logic [31:0] i,
                       input logic [4:0] ra, input logic [31:0] rdd, input logic rv,
                       input logic [4:0] a1, input logic [4:0] a2);
    @(negedge clk);
    stall = s; flush = f; pc = p; instr = i;
    rd_port.addr = ra; rd_port.data = rdd; rd_port.valid = rv;
    rs1 = a1; rs2 = a2;
    #1;
  endtask

  task automatic apply_edge();
    bit ret, we, pop, full;
    ret = m_retire();
    we  = m_we();
    if (rst) begin
      for (int r = 0; r < 32; r++) m_regs[r] = 32'h0;
      m_cnt = 0; m_cv = 0; m_cwe = 0; m_ovf = 0;
      m_cpc = 0; m_cinstr = 0; m_crd_data = 0; m_crd_addr = 0;
      m_fifo.delete();
    end else begin
      if (we) m_regs[rd_port.addr] = rd_port.data;
      if (ret) m_cnt = m_cnt + 64'd1;
      m_cv = ret; m_cwe = we; m_cpc = pc; m_cinstr = instr;
      m_crd_addr = rd_port.addr; m_crd_data = rd_port.data;
`ifdef COMMIT_TRACE_EN
      full = (m_fifo.size() == DEPTH);
      pop  = (m_fifo.size() > 0) && tready;
      if (pop) void'(m_fifo.pop_front());
      if (ret) begin
        if (!full || pop) m_fifo.push_back({pc, instr});
        else m_ovf = 1'b1;
      end
`endif
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    apply_edge();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (retire_cnt !== 64'd0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", retire_cnt); end
    n_cmp++; if (commit_valid !== 1'b0 || commit_we !== 1'b0 || commit_pc !== 32'h0) begin
      n_err++; $display("FAIL reset_commit: got v=%b we=%b pc=%h want 0/0/0", commit_valid, commit_we, commit_pc); end
    n_cmp++; if (trace_valid !== 1'b0 || trace_ovf !== 1'b0) begin
      n_err++; $display("FAIL reset_trace: got v=%b ovf=%b want 0/0", trace_valid, trace_ovf); end
    for (int a = 1; a < 32; a++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 5'(a), 5'(31 - a + 1));
      n_cmp++; if (rs1_data !== 32'h0 || rs2_data !== 32'h0) begin
        n_err++; $display("FAIL reset_reg x%0d: got %h/%h want 0", a, rs1_data, rs2_data); end
    end
  endtask

  task automatic test_bypass();
    do_reset();
    drive(0, 0, 32'h0, 32'h00A00093, 5'd1, 32'hA, 1'b1, 5'd1, 5'd2);
    n_cmp++; if (rs1_data !== 32'hA) begin n_err++; $display("FAIL bypass_rs1: got %h want a", rs1_data); end
    n_cmp++; if (rs2_data !== 32'h0) begin n_err++; $display("FAIL bypass_rs2: got %h want 0", rs2_data); end
    apply_edge();
    drive(0, 0, 32'h4, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd1);
    n_cmp++; if (rs2_data !== 32'hA) begin n_err++; $display("FAIL regs_x1: got %h want a", rs2_data); end
    n_cmp++; if (retire_cnt !== 64'd1) begin n_err++; $display("FAIL bypass_cnt: got %0d want 1", retire_cnt); end
    n_cmp++; if (commit_we !== 1'b1 || commit_valid !== 1'b1 || commit_rd_addr !== 5'd1 ||
                 commit_rd_data !== 32'hA || commit_instr !== 32'h00A00093) begin
      n_err++; $display("FAIL bypass_commit: got we=%b v=%b rd=%0d d=%h i=%h want 1/1/1/a/00a00093",
                        commit_we, commit_valid, commit_rd_addr, commit_rd_data, commit_instr); end
  endtask

  task automatic test_x0();
    drive(0, 0, 32'h8, 32'h00000013, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 5'd0);
    n_cmp++; if (rs1_data !== 32'h0) begin n_err++; $display("FAIL x0_read: got %h want 0", rs1_data); end
    apply_edge();
    n_cmp++; if (commit_we !== 1'b0 || commit_valid !== 1'b1) begin
      n_err++; $display("FAIL x0_commit: got we=%b v=%b want 0/1", commit_we, commit_valid); end
    n_cmp++; if (retire_cnt !== 64'd2) begin n_err++; $display("FAIL x0_cnt: got %0d want 2", retire_cnt); end
  endtask

  task automatic test_no_retire();
    logic [2:0] cases [4] = '{3'b000, 3'b101, 3'b011, 3'b111};  // {stall, flush, nonzero instr}
    for (int k = 0; k < 4; k++) begin
      drive(cases[k][2], cases[k][1], 32'h40, cases[k][0] ? 32'h05500293 : 32'h0,
            5'd5, 32'h55, 1'b1, 5'd5, 5'd0);
      n_cmp++; if (rs1_data !== 32'h0) begin n_err++; $display("FAIL noret_bypass case%0d: got %h want 0", k, rs1_data); end
      apply_edge();
      n_cmp++; if (retire_cnt !== 64'd2 || commit_valid !== 1'b0 || commit_we !== 1'b0) begin
        n_err++; $display("FAIL noret_state case%0d: got cnt=%0d v=%b we=%b want 2/0/0",
                          k, retire_cnt, commit_valid, commit_we); end
    end
    drive(0, 0, 0, 0, 0, 0, 0, 5'd5, 5'd0);
    n_cmp++; if (rs1_data !== 32'h0) begin n_err++; $display("FAIL noret_x5: got %h want 0", rs1_data); end
  endtask

  task automatic test_cnt_wrap();
    do_reset();
    @(negedge clk);
    dut.retire_cnt_q = 64'hFFFF_FFFF_FFFF_FFFF;
    m_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
    drive(0, 0, 32'h100, 32'h13, 5'd0, 0, 1'b0, 0, 0);
    apply_edge();
    n_cmp++; if (retire_cnt !== 64'd0) begin n_err++; $display("FAIL cnt_wrap: got %h want 0", retire_cnt); end
    drive(0, 0, 32'h104, 32'h13, 5'd0, 0, 1'b0, 0, 0);
    apply_edge();
    n_cmp++; if (retire_cnt !== 64'd1) begin n_err++; $display("FAIL cnt_after_wrap: got %0d want 1", retire_cnt); end
  endtask

`ifdef COMMIT_TRACE_EN
  task automatic test_trace_overflow();
    do_reset();
    tready = 1'b0;
    for (int k = 0; k < 9; k++) begin
      drive(0, 0, 32'(4 * k), 32'h13 + 32'(k), 5'd0, 0, 1'b0, 0, 0);
      apply_edge();
      n_cmp++; if (trace_ovf !== (k == 8) || trace_valid !== 1'b1 || trace_pc !== 32'h0) begin
        n_err++; $display("FAIL trace_fill %0d: got ovf=%b v=%b pc=%h want %b/1/0", k, trace_ovf, trace_valid, trace_pc, k == 8); end
    end
    tready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      n_cmp++; if (trace_valid !== 1'b1 || trace_pc !== 32'(4 * k) || trace_instr !== 32'h13 + 32'(k)) begin
        n_err++; $display("FAIL trace_drain %0d: got v=%b pc=%h i=%h want 1/%h/%h",
                          k, trace_valid, trace_pc, trace_instr, 4 * k, 32'h13 + 32'(k)); end
      apply_edge();
    end
    n_cmp++; if (trace_valid !== 1'b0 || trace_ovf !== 1'b1) begin
      n_err++; $display("FAIL trace_empty: got v=%b ovf=%b want 0/1", trace_valid, trace_ovf); end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] exp_pc [8];
    do_reset();
    tready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      drive(0, 0, 32'h100 + 32'(4 * k), 32'h13, 5'(k + 1), 32'hC0 + 32'(k), 1'b1, 0, 0);
      apply_edge();
    end
    tready = 1'b1;
    drive(0, 0, 32'h200, 32'h13, 5'd0, 0, 1'b0, 0, 0);
    apply_edge();
    n_cmp++; if (trace_ovf !== 1'b0 || trace_valid !== 1'b1 || trace_pc !== 32'h104) begin
      n_err++; $display("FAIL pushpop_full: got ovf=%b v=%b pc=%h want 0/1/104", trace_ovf, trace_valid, trace_pc); end
    for (int k = 0; k < 7; k++) exp_pc[k] = 32'h104 + 32'(4 * k);
    exp_pc[7] = 32'h200;
    for (int k = 0; k < 8; k++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      n_cmp++; if (trace_pc !== exp_pc[k] || trace_valid !== 1'b1) begin
        n_err++; $display("FAIL pushpop_drain %0d: got v=%b pc=%h want 1/%h", k, trace_valid, trace_pc, exp_pc[k]); end
      apply_edge();
    end
    tready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 32'h300 + 32'(4 * k), 32'h13, 0, 0, 0, 0, 0);
      apply_edge();
    end
    tready = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    apply_edge();
    rst = 1'b1;
    drive(0, 0, 32'h400, 32'h13, 5'd9, 32'h99, 1'b1, 0, 0);
    apply_edge();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 5'd3, 5'd9);
    n_cmp++; if (trace_valid !== 1'b0 || retire_cnt !== 64'd0 || rs1_data !== 32'h0 || rs2_data !== 32'h0) begin
      n_err++; $display("FAIL mid_reset: got v=%b cnt=%0d x3=%h x9=%h want 0/0/0/0",
                        trace_valid, retire_cnt, rs1_data, rs2_data); end
  endtask
`else
  task automatic test_trace_tied();
    do_reset();
    for (int k = 0; k < 10; k++) begin
      tready = 1'($urandom_range(0, 1));
      drive(0, 0, 32'(4 * k), 32'h13, 0, 0, 0, 0, 0);
      apply_edge();
      n_cmp++; if (trace_valid !== 1'b0 || trace_ovf !== 1'b0 || trace_pc !== 32'h0 || trace_instr !== 32'h0) begin
        n_err++; $display("FAIL trace_tied %0d: got v=%b ovf=%b pc=%h i=%h want all 0",
                          k, trace_valid, trace_ovf, trace_pc, trace_instr); end
    end
  endtask
`endif

  task automatic test_random();
    logic [4:0] ra;
    logic [63:0] head;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      rst    = ($urandom_range(0, 63) == 0);
      tready = 1'($urandom_range(0, 1));
      ra     = 5'($urandom_range(0, 31));
      drive(($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0), $urandom(),
            ($urandom_range(0, 4) == 0) ? 32'h0 : ($urandom() | 32'h1),
            ra, $urandom(), 1'($urandom_range(0, 3) != 0),
            ($urandom_range(0, 1) == 1) ? ra : 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      n_cmp++; if (rs1_data !== m_read(rs1) || rs2_data !== m_read(rs2)) begin
        n_err++; $display("FAIL rnd_read %0d: got %h/%h want %h/%h", n, rs1_data, rs2_data, m_read(rs1), m_read(rs2)); end
`ifdef COMMIT_TRACE_EN
      head = (m_fifo.size() > 0) ? m_fifo[0] : 64'h0;
      n_cmp++; if (trace_valid !== (m_fifo.size() > 0) || trace_ovf !== m_ovf ||
                   (m_fifo.size() > 0 && {trace_pc, trace_instr} !== head)) begin
        n_err++; $display("FAIL rnd_trace %0d: got v=%b ovf=%b head=%h want %b/%b/%h",
                          n, trace_valid, trace_ovf, {trace_pc, trace_instr}, m_fifo.size() > 0, m_ovf, head); end
`else
      head = 64'h0;
      n_cmp++; if (trace_valid !== 1'b0 || {trace_pc, trace_instr} !== head) begin
        n_err++; $display("FAIL rnd_trace %0d: got v=%b head=%h want 0", n, trace_valid, {trace_pc, trace_instr}); end
`endif
      apply_edge();
      n_cmp++; if (retire_cnt !== m_cnt || commit_valid !== m_cv || commit_we !== m_cwe ||
                   commit_pc !== m_cpc || commit_instr !== m_cinstr ||
                   commit_rd_addr !== m_crd_addr || commit_rd_data !== m_crd_data) begin
        n_err++; $display("FAIL rnd_commit %0d: got cnt=%0d v=%b we=%b pc=%h want cnt=%0d v=%b we=%b pc=%h",
                          n, retire_cnt, commit_valid, commit_we, commit_pc, m_cnt, m_cv, m_cwe, m_cpc); end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; flush = 1'b0; tready = 1'b0;
    pc = '0; instr = '0; rd_port = '0; rs1 = '0; rs2 = '0;
    test_reset();
    test_bypass();
    test_x0();
    test_no_retire();
    test_cnt_wrap();
`ifdef COMMIT_TRACE_EN
    test_trace_overflow();
    test_full_push_pop();
`else
    test_trace_tied();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
